// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer and the ROM instance.
// The state encoding and the default ROM geometry live here so the ROM and the fetch logic agree on them.
package inst_fetch_ctrl_pkg;

    localparam int INST_WORD_W   = 32;
    localparam int PC_STEP       = 4;
    localparam int ROM_DEPTH_DEF = 20;
    localparam int ADDR_W_DEF    = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_t;

    // Compares the full 30-bit word index against the depth.
    // Using the truncated ROM address here could wrap past the end of the image.
    function automatic logic pc_in_image(input logic [31:0] pc, input logic [31:0] depth);
        logic [31:0] word_idx;
        word_idx = {2'b00, pc[31:2]};
        return word_idx < depth;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if_stage_reg.sv
// Valid/ready output register toward decode; holds one fetched word and its byte PC.
// A flush clears the valid bit whether or not decode is ready; a load takes priority over consumption.
module if_stage_reg
    import inst_fetch_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   load,
    input  logic                   id_ready,
    input  logic [INST_WORD_W-1:0] inst_in,
    input  logic [31:0]            pc_in,
    output logic                   valid,
    output logic [INST_WORD_W-1:0] inst,
    output logic [31:0]            pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= inst_in;
            pc    <= pc_in;
        end else if (valid && id_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction ROM sequencer: owns the PC, issues fetched words into the output stage and applies redirects.
//   state   | meaning
//   ST_IDLE | parked; PC retained, waiting for start
//   ST_RUN  | fetching one word per accepted slot
//   ST_HALT | ran past the image or took a misaligned redirect; left only via rst
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int          ROM_DEPTH = ROM_DEPTH_DEF,
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [INST_WORD_W-1:0] rom_inst,
    output logic                   if_valid,
    output logic [INST_WORD_W-1:0] if_inst,
    output logic [31:0]            if_pc,
    input  logic                   id_ready,
    input  logic                   br_taken,
    input  logic [31:0]            br_target,
    output logic                   busy,
    output logic                   done,
    output logic                   fault,
    output logic [15:0]            fetch_cnt
);

    localparam logic [31:0] DEPTH = 32'(ROM_DEPTH);
    localparam logic [31:0] STEP  = 32'(PC_STEP);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic         done_nxt, fault_nxt;
    logic [15:0]  cnt_nxt;
    logic         stage_load, stage_flush;
    logic         advance, in_image;

    assign rom_addr = pc[ADDR_W+1:2];
    assign busy     = (state == ST_RUN);
    assign advance  = !if_valid || id_ready;
    assign in_image = pc_in_image(pc, DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            done      <= 1'b0;
            fault     <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            done      <= done_nxt;
            fault     <= fault_nxt;
            fetch_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        done_nxt    = done;
        fault_nxt   = fault;
        cnt_nxt     = fetch_cnt;
        stage_load  = 1'b0;
        stage_flush = 1'b0;

        // A redirect outranks issue, backpressure and stop; HALT ignores it.
        if (br_taken && (state == ST_IDLE || state == ST_RUN)) begin
            stage_flush = 1'b1;
            if (br_target[1:0] == 2'b00) begin
                pc_nxt = br_target;
                if (state == ST_RUN && stop) begin
                    state_nxt = ST_IDLE;
                end else if (state == ST_IDLE && start) begin
                    state_nxt = ST_RUN;
                end
            end else begin
                state_nxt = ST_HALT;
                fault_nxt = 1'b1;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_nxt = ST_IDLE;
                    end else if (advance) begin
                        if (in_image) begin
                            stage_load = 1'b1;
                            pc_nxt     = pc + STEP;
                            if (fetch_cnt != 16'hFFFF) begin
                                cnt_nxt = fetch_cnt + 16'd1;
                            end
                        end else begin
                            stage_flush = 1'b1;
                            state_nxt   = ST_HALT;
                            done_nxt    = 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    state_nxt = ST_HALT;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    if_stage_reg u_if_stage (
        .clk      (clk),
        .rst      (rst),
        .flush    (stage_flush),
        .load     (stage_load),
        .id_ready (id_ready),
        .inst_in  (rom_inst),
        .pc_in    (pc),
        .valid    (if_valid),
        .inst     (if_inst),
        .pc       (if_pc)
    );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus a randomized run.
// The reference is the program-order stream of (pc, word) that decode should receive, restarted at each redirect.
module tb_inst_fetch_ctrl;

    localparam int ROM_DEPTH = 20;
    localparam int ADDR_W    = 5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_inst;
    logic              if_valid;
    logic [31:0]       if_inst;
    logic [31:0]       if_pc;
    logic              id_ready = 1'b0;
    logic              br_taken = 1'b0;
    logic [31:0]       br_target = '0;
    logic              busy;
    logic              done;
    logic              fault;
    logic [15:0]       fetch_cnt;

    logic [31:0] rom [0:(1<<ADDR_W)-1];
    exp_t        exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    assign rom_inst = rom[rom_addr];

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.ROM_DEPTH(ROM_DEPTH), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .rom_addr  (rom_addr),
        .rom_inst  (rom_inst),
        .if_valid  (if_valid),
        .if_inst   (if_inst),
        .if_pc     (if_pc),
        .id_ready  (id_ready),
        .br_taken  (br_taken),
        .br_target (br_target),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .fetch_cnt (fetch_cnt)
    );

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Everything from the restart point to the end of the image, in order.
    task automatic model_restart(input int target);
        exp_t e;
        exp_q.delete();
        for (int a = target; a < ROM_DEPTH * 4; a += 4) begin
            e.pc   = 32'(a);
            e.inst = rom[a / 4];
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; br_taken = 1'b0; id_ready = 1'b0;
        tick();
        check1("rst_if_valid", if_valid, 1'b0);
        check32("rst_if_inst", if_inst, 32'h0);
        check32("rst_if_pc", if_pc, 32'h0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_fault", fault, 1'b0);
        check32("rst_fetch_cnt", 32'(fetch_cnt), 32'h0);
        check32("rst_rom_addr", 32'(rom_addr), 32'h0);
        rst = 1'b0;
        model_restart(0);
    endtask

    // Monitor: every handshake must deliver the next word of the expected stream.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if_valid && id_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL stream_extra: got pc %h inst %h expected no transfer", if_pc, if_inst);
            end else begin
                e = exp_q.pop_front();
                if (if_pc !== e.pc || if_inst !== e.inst) begin
                    n_bad++;
                    $display("FAIL stream: got pc %h inst %h expected pc %h inst %h",
                             if_pc, if_inst, e.pc, e.inst);
                end
            end
        end
    end

    initial begin
        logic [31:0] last_pc;
        logic [ADDR_W-1:0] saved_addr;
        bit finished;

        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = $urandom;
        rom[0] = 32'h24010001;
        rom[1] = 32'h00011100;
        rom[2] = 32'h00411825;
        rom[8] = 32'h08000000;

        // Start and sequential fetch
        do_reset();
        id_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check1("start_busy", busy, 1'b1);
        check1("start_no_valid_yet", if_valid, 1'b0);
        tick();
        check32("fetch0_pc", if_pc, 32'h00);
        check32("fetch0_inst", if_inst, 32'h24010001);
        check32("fetch0_rom_addr", 32'(rom_addr), 32'd1);
        tick();
        check32("fetch1_pc", if_pc, 32'h04);
        check32("fetch1_inst", if_inst, 32'h00011100);
        tick();
        check32("fetch2_pc", if_pc, 32'h08);
        check32("fetch2_inst", if_inst, 32'h00411825);
        check32("fetch2_rom_addr", 32'(rom_addr), 32'd3);

        // Backpressure
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check32("bp_if_pc", if_pc, 32'h08);
            check1("bp_if_valid", if_valid, 1'b1);
            check32("bp_rom_addr", 32'(rom_addr), 32'd3);
            check32("bp_fetch_cnt", 32'(fetch_cnt), 32'd3);
        end
        id_ready = 1'b1;
        tick();
        check32("bp_release_pc", if_pc, 32'h0C);
        check32("bp_release_cnt", 32'(fetch_cnt), 32'd4);

        // Redirect while holding an unconsumed word
        id_ready = 1'b0; br_taken = 1'b1; br_target = 32'h20;
        model_restart(32'h20);
        tick();
        br_taken = 1'b0;
        check1("br_bubble_valid", if_valid, 1'b0);
        check32("br_rom_addr", 32'(rom_addr), 32'd8);
        tick();
        check1("br_target_valid", if_valid, 1'b1);
        check32("br_target_pc", if_pc, 32'h20);
        check32("br_target_inst", if_inst, 32'h08000000);
        id_ready = 1'b1;

        // End of image, no redirects
        do_reset();
        id_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        last_pc = 32'hFFFF_FFFF;
        finished = 1'b0;
        for (int c = 0; c < 60 && !finished; c++) begin
            tick();
            if (if_valid) last_pc = if_pc;
            if (done) finished = 1'b1;
        end
        check1("eoi_done_within_budget", finished, 1'b1);
        check32("eoi_last_pc", last_pc, 32'h4C);
        check1("eoi_done", done, 1'b1);
        check1("eoi_fault", fault, 1'b0);
        check1("eoi_if_valid", if_valid, 1'b0);
        check1("eoi_busy", busy, 1'b0);
        check32("eoi_fetch_cnt", 32'(fetch_cnt), 32'd20);
        check32("eoi_stream_drained", 32'(exp_q.size()), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("eoi_start_ignored", busy, 1'b0);

        // Misaligned redirect
        do_reset();
        id_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        id_ready = 1'b0; br_taken = 1'b1; br_target = 32'h22;
        exp_q.delete();
        saved_addr = rom_addr;
        tick();
        br_taken = 1'b0;
        check1("bad_fault", fault, 1'b1);
        check1("bad_done", done, 1'b0);
        check1("bad_if_valid", if_valid, 1'b0);
        check1("bad_busy", busy, 1'b0);
        check32("bad_pc_kept", 32'(rom_addr), 32'(saved_addr));
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("bad_start_ignored", busy, 1'b0);
        id_ready = 1'b1;
        tick();
        check1("bad_stays_empty", if_valid, 1'b0);

        // Reset while holding a word under backpressure
        do_reset();
        id_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        id_ready = 1'b0;
        tick();
        check1("midrst_holding", if_valid, 1'b1);
        do_reset();

        // stop and redirect together
        id_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        stop = 1'b1; br_taken = 1'b1; br_target = 32'h10; id_ready = 1'b0;
        model_restart(32'h10);
        tick();
        stop = 1'b0; br_taken = 1'b0;
        check1("stopbr_busy", busy, 1'b0);
        check1("stopbr_valid", if_valid, 1'b0);
        check32("stopbr_rom_addr", 32'(rom_addr), 32'd4);
        id_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check1("stopbr_restart_busy", busy, 1'b1);
        tick();
        check1("stopbr_first_valid", if_valid, 1'b1);
        check32("stopbr_first_pc", if_pc, 32'h10);

        // Randomized run: backpressure, redirects, stop/start
        do_reset();
        finished = 1'b0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            br_taken = 1'b0; start = 1'b0; stop = 1'b0;
            if (c < 400 && $urandom_range(0, 19) == 0) begin
                br_taken  = 1'b1;
                id_ready  = 1'b0;
                br_target = 32'($urandom_range(0, ROM_DEPTH - 1)) << 2;
                model_restart(int'(br_target));
            end else begin
                id_ready = ($urandom_range(0, 9) < 7);
            end
            if ($urandom_range(0, 29) == 0) stop = 1'b1;
            if (!busy && $urandom_range(0, 3) == 0) start = 1'b1;
            tick();
            if (done) finished = 1'b1;
        end
        br_taken = 1'b0; start = 1'b0; stop = 1'b0;
        check1("rand_done_within_budget", finished, 1'b1);
        check1("rand_fault", fault, 1'b0);
        check32("rand_stream_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
